draw_scheduler: RTL

Buffers rectangle fill commands from game logic and issues them one at a time to `screen_writer`. Each command is clipped to the visible area, then started with a one-cycle `screen_start` pulse. The block holds the rectangle fields stable until `screen_done` returns, so logic can queue several fills without tracking writer status. It sits directly upstream of `screen_writer` and drives all of that block's "from logic" inputs.

---
 rtl/draw_scheduler_pkg.sv | 17 +
 rtl/draw_scheduler_if.sv | 33 +++
 rtl/draw_scheduler_cmd_fifo.sv | 50 +++++
 rtl/draw_scheduler.sv | 107 ++++++++++
 4 files changed

// File: rtl/draw_scheduler_pkg.sv
// rtl/draw_scheduler_pkg.sv - shared FSM encoding and command packing helpers for draw_scheduler
package draw_scheduler_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2
  } state_t;

  localparam int DROP_WIDTH = 8;

  // Commands are packed as {colour, y_range, x_range, y_min, x_min}.
  function automatic int cmd_bits(input int width, input int colour_width);
    return 4 * width + colour_width;
  endfunction

endpackage

// File: rtl/draw_scheduler_if.sv
// rtl/draw_scheduler_if.sv - command stream from game logic and rectangle bus to screen_writer
interface draw_scheduler_if #(
  parameter int WIDTH        = 8,
  parameter int COLOUR_WIDTH = 3
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [WIDTH-1:0]        cmd_x_min;
  logic [WIDTH-1:0]        cmd_y_min;
  logic [WIDTH-1:0]        cmd_x_range;
  logic [WIDTH-1:0]        cmd_y_range;
  logic [COLOUR_WIDTH-1:0] cmd_colour;

  logic                    screen_start;
  logic [COLOUR_WIDTH-1:0] new_screen_colour;
  logic [WIDTH-1:0]        screen_x_min;
  logic [WIDTH-1:0]        screen_y_min;
  logic [WIDTH-1:0]        screen_x_range;
  logic [WIDTH-1:0]        screen_y_range;
  logic                    screen_done;

  modport master (
    output cmd_valid, cmd_x_min, cmd_y_min, cmd_x_range, cmd_y_range, cmd_colour, screen_done,
    input  cmd_ready, screen_start, new_screen_colour, screen_x_min, screen_y_min,
           screen_x_range, screen_y_range
  );

  modport slave (
    input  cmd_valid, cmd_x_min, cmd_y_min, cmd_x_range, cmd_y_range, cmd_colour, screen_done,
    output cmd_ready, screen_start, new_screen_colour, screen_x_min, screen_y_min,
           screen_x_range, screen_y_range
  );
endinterface

// File: rtl/draw_scheduler_cmd_fifo.sv
// rtl/draw_scheduler_cmd_fifo.sv - single-clock command FIFO with async-reset pointers
module cmd_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [DATA_WIDTH-1:0]  push_data,
  input  logic                   pop,
  output logic [DATA_WIDTH-1:0]  pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/draw_scheduler.sv
// rtl/draw_scheduler.sv - queues rectangle fills, clips them and issues them one at a time to screen_writer
module draw_scheduler
  import draw_scheduler_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int COLOUR_WIDTH = 3,
  parameter int DEPTH        = 4,
  parameter int X_LAST       = 159,
  parameter int Y_LAST       = 119
) (
  input  logic                   clock,
  input  logic                   reset,
  draw_scheduler_if.slave        bus,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [DROP_WIDTH-1:0]  dropped_count
);
  localparam int             CMD_W = cmd_bits(WIDTH, COLOUR_WIDTH);
  localparam logic [WIDTH:0] X_LIM = (WIDTH+1)'(X_LAST);
  localparam logic [WIDTH:0] Y_LIM = (WIDTH+1)'(Y_LAST);

  state_t                  state, next_state;
  logic [CMD_W-1:0]        push_data, head;
  logic                    full, empty, push, pop, load, drop;
  logic [WIDTH-1:0]        h_x_min, h_y_min, h_x_range, h_y_range;
  logic [COLOUR_WIDTH-1:0] h_colour;
  logic [WIDTH:0]          x_sum, y_sum;
  logic [WIDTH-1:0]        clip_x_range, clip_y_range;
  logic                    off_screen;

  assign push_data     = {bus.cmd_colour, bus.cmd_y_range, bus.cmd_x_range, bus.cmd_y_min, bus.cmd_x_min};
  assign bus.cmd_ready = !full;
  assign push          = bus.cmd_valid && !full;

  cmd_fifo #(.DATA_WIDTH(CMD_W), .DEPTH(DEPTH)) u_cmd_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  assign {h_colour, h_y_range, h_x_range, h_y_min, h_x_min} = head;

  // Sums are one bit wider so a wrap past 2**WIDTH still reads as off the right/bottom edge.
  assign x_sum        = {1'b0, h_x_min} + {1'b0, h_x_range};
  assign y_sum        = {1'b0, h_y_min} + {1'b0, h_y_range};
  assign clip_x_range = (x_sum > X_LIM) ? X_LIM[WIDTH-1:0] - h_x_min : h_x_range;
  assign clip_y_range = (y_sum > Y_LIM) ? Y_LIM[WIDTH-1:0] - h_y_min : h_y_range;
  assign off_screen   = ({1'b0, h_x_min} > X_LIM) || ({1'b0, h_y_min} > Y_LIM);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    load       = 1'b0;
    drop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (off_screen) begin
            drop = 1'b1;
          end else begin
            load       = 1'b1;
            next_state = S_START;
          end
        end
      end
      S_START: next_state = S_BUSY;
      S_BUSY:  if (bus.screen_done) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  assign bus.screen_start = (state == S_START);
  assign busy             = !empty || (state != S_IDLE);

  // Writer fields are held from the loading edge until the next load.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.screen_x_min      <= '0;
      bus.screen_y_min      <= '0;
      bus.screen_x_range    <= '0;
      bus.screen_y_range    <= '0;
      bus.new_screen_colour <= '0;
      dropped_count         <= '0;
    end else begin
      if (load) begin
        bus.screen_x_min      <= h_x_min;
        bus.screen_y_min      <= h_y_min;
        bus.screen_x_range    <= clip_x_range;
        bus.screen_y_range    <= clip_y_range;
        bus.new_screen_colour <= h_colour;
      end
      if (drop && dropped_count != {DROP_WIDTH{1'b1}}) dropped_count <= dropped_count + 1'b1;
    end
  end
endmodule
